// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiplier and restoring
// divider sharing one XLEN+1-bit adder, with valid/ready on both sides.
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;
    state_t state, state_nxt;

    logic [2:0]      f3_q;
    logic [XLEN-1:0] a_q, b_q;
    logic [XLEN-1:0] hi, lo, mcand;
    logic            neg_q;
    logic [CW-1:0]   count;

    // operand decode on the latched instruction
    logic            is_div, is_rem, signed1, signed2, sign1, sign2;
    logic [XLEN-1:0] abs1, abs2;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] special_res;

    assign is_div  = f3_q[2];
    assign is_rem  = f3_q[2] & f3_q[1];
    assign signed1 = is_div ? ~f3_q[0] : (f3_q == 3'b001 || f3_q == 3'b010);
    assign signed2 = is_div ? ~f3_q[0] : (f3_q == 3'b001);
    assign sign1   = signed1 & a_q[XLEN-1];
    assign sign2   = signed2 & b_q[XLEN-1];
    assign abs1    = sign1 ? -a_q : a_q;
    assign abs2    = sign2 ? -b_q : b_q;

    assign div_zero = is_div && (b_q == '0);
    assign div_ovf  = is_div && signed1 && (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == '1);
    assign special  = div_zero | div_ovf;

    always_comb begin
        special_res = '0;
        if (div_zero) special_res = is_rem ? a_q : '1;
        else          special_res = is_rem ? '0  : a_q;
    end

    // Shared adder: multiply adds the multiplicand into the upper half; divide
    // subtracts the divisor from the shifted remainder, carry-out means no borrow.
    logic [XLEN:0]   add_a, add_b;
    logic            add_cin;
    logic [XLEN+1:0] add_sum;
    logic            trial_ok;

    always_comb begin
        if (is_div) begin
            add_a   = {hi, lo[XLEN-1]};
            add_b   = ~{1'b0, mcand};
            add_cin = 1'b1;
        end else begin
            add_a   = {1'b0, hi};
            add_b   = lo[0] ? {1'b0, mcand} : '0;
            add_cin = 1'b0;
        end
    end

    assign add_sum  = {1'b0, add_a} + {1'b0, add_b} + {{(XLEN+1){1'b0}}, add_cin};
    assign trial_ok = add_sum[XLEN+1];

    // sign fix-up and output selection
    logic [2*XLEN-1:0] prod_f;
    logic [XLEN-1:0]   quo_f, rem_f, fix_res;

    assign prod_f = neg_q ? -{hi, lo} : {hi, lo};
    assign quo_f  = neg_q ? -lo : lo;
    assign rem_f  = neg_q ? -hi : hi;

    always_comb begin
        fix_res = '0;
        if (is_div)             fix_res = f3_q[1] ? rem_f : quo_f;
        else if (f3_q == 3'b000) fix_res = prod_f[XLEN-1:0];
        else                    fix_res = prod_f[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = PREP;
            PREP: state_nxt = special ? DONE : ITER;
            ITER: if (count == '0) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (kill) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            f3_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            hi     <= '0;
            lo     <= '0;
            mcand  <= '0;
            neg_q  <= 1'b0;
            count  <= '0;
            result <= '0;
        end else if (!kill) begin
            case (state)
                IDLE: if (in_valid) begin
                    f3_q <= funct3;
                    a_q  <= rs1;
                    b_q  <= rs2;
                end
                PREP: begin
                    count <= CW'(XLEN-1);
                    hi    <= '0;
                    neg_q <= is_rem ? sign1 : (sign1 ^ sign2);
                    // divide keeps the dividend in lo and the divisor in mcand
                    lo    <= is_div ? abs1 : abs2;
                    mcand <= is_div ? abs2 : abs1;
                    if (special) result <= special_res;
                end
                ITER: begin
                    count <= count - 1'b1;
                    if (is_div) begin
                        hi <= trial_ok ? add_sum[XLEN-1:0] : {hi[XLEN-2:0], lo[XLEN-1]};
                        lo <= {lo[XLEN-2:0], trial_ok};
                    end else begin
                        hi <= add_sum[XLEN:1];
                        lo <= {add_sum[0], lo[XLEN-1:1]};
                    end
                end
                FIX: result <= fix_res;
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Table of RV32M vectors with scoreboard-checked results and latency, plus
// hand sequences for back-pressure, kill and reset in flight.
module tb_muldiv_sequencer;
    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, kill, out_valid, out_ready, busy;
    logic [2:0]  funct3;
    logic [31:0] rs1, rs2, result;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb[$];

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .funct3(funct3), .rs1(rs1), .rs2(rs2), .kill(kill),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input string nm, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input bit push);
        chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
        funct3   = f3;
        rs1      = a;
        rs2      = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        if (push) sb.push_back(exp);
    endtask

    task automatic wait_done(input string nm, input int exp_lat);
        int lat;
        lat = 0;
        while (lat < 100) begin
            tick();
            lat++;
            if (out_valid) break;
        end
        chk({nm, "_latency"}, 32'(lat), 32'(exp_lat));
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_scoreboard: got empty queue required one entry", nm);
        end else begin
            chk(nm, result, sb.pop_front());
        end
    endtask

    task automatic retire(input string nm);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({nm, "_ready_after"}, {30'd0, in_ready, out_valid}, 32'b10);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; kill = 1'b0; out_ready = 1'b0;
        funct3 = '0; rs1 = '0; rs2 = '0;
        repeat (3) tick();
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_result",    result,         32'd0);
        reset = 1'b0;
        tick();

        vecs.push_back('{3'b000, 32'd7,          32'd6,          32'd42,         34});
        vecs.push_back('{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  34});
        vecs.push_back('{3'b001, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0,          34});
        vecs.push_back('{3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  34});
        vecs.push_back('{3'b000, 32'h8000_0000,  32'd2,          32'h0,          34});
        vecs.push_back('{3'b001, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  34});
        vecs.push_back('{3'b100, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34});
        vecs.push_back('{3'b110, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34});
        vecs.push_back('{3'b100, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  34});
        vecs.push_back('{3'b110, 32'd7,          32'hFFFF_FFFE,  32'd1,          34});
        vecs.push_back('{3'b101, 32'd100,        32'd7,          32'd14,         34});
        vecs.push_back('{3'b111, 32'd100,        32'd7,          32'd2,          34});
        vecs.push_back('{3'b101, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          34});
        vecs.push_back('{3'b100, 32'd5,          32'd0,          32'hFFFF_FFFF,  1});
        vecs.push_back('{3'b110, 32'd5,          32'd0,          32'd5,          1});
        vecs.push_back('{3'b101, 32'd5,          32'd0,          32'hFFFF_FFFF,  1});
        vecs.push_back('{3'b111, 32'd5,          32'd0,          32'd5,          1});
        vecs.push_back('{3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1});
        vecs.push_back('{3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          1});

        foreach (vecs[i]) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            issue(nm, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b1);
            if (vecs[i].lat > 1)
                chk({nm, "_busy"}, {30'd0, busy, in_ready}, 32'b10);
            wait_done(nm, vecs[i].lat);
            retire(nm);
        end

        // back-pressure in DONE while a new request is already being offered
        issue("hold_mul", 3'b000, 32'd7, 32'd6, 32'd42, 1'b1);
        wait_done("hold_mul", 34);
        funct3 = 3'b101; rs1 = 32'd100; rs2 = 32'd7; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("hold%0d_result", k), result, 32'd42);
            chk($sformatf("hold%0d_flags", k), {30'd0, in_ready, out_valid}, 32'b01);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("hold_release", {30'd0, in_ready, out_valid}, 32'b10);
        tick();
        in_valid = 1'b0;
        sb.push_back(32'd14);
        chk("hold_next_accept", {30'd0, busy, in_ready}, 32'b10);
        wait_done("hold_divu", 34);
        retire("hold_divu");

        // kill on the acceptance edge discards the request
        funct3 = 3'b000; rs1 = 32'd3; rs2 = 32'd3; in_valid = 1'b1; kill = 1'b1;
        tick();
        in_valid = 1'b0; kill = 1'b0;
        chk("kill_accept", {30'd0, busy, in_ready}, 32'b01);

        // kill during ITER cycle 10
        issue("kill_iter", 3'b101, 32'd1000, 32'd3, 32'd0, 1'b0);
        repeat (11) tick();
        chk("kill_pre_busy", 32'(busy), 32'd1);
        kill = 1'b1;
        tick();
        kill = 1'b0;
        chk("kill_flags", {29'd0, in_ready, busy, out_valid}, 32'b100);
        chk("kill_result_held", result, 32'd14);
        begin
            int seen;
            seen = 0;
            for (int k = 0; k < 40; k++) begin
                tick();
                if (out_valid) seen++;
            end
            chk("kill_no_valid", 32'(seen), 32'd0);
        end
        issue("post_kill", 3'b111, 32'd100, 32'd7, 32'd2, 1'b1);
        wait_done("post_kill", 34);
        retire("post_kill");

        // reset while in FIX
        issue("rst_fix", 3'b000, 32'd7, 32'd6, 32'd0, 1'b0);
        repeat (33) tick();
        chk("rst_fix_pre", {30'd0, busy, out_valid}, 32'b10);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_fix_flags", {29'd0, in_ready, busy, out_valid}, 32'b100);
        chk("rst_fix_result", result, 32'd0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
